apb_vmac: RTL and testbench
===========================

APB_VMAC -- requirements
Module: apb_vmac

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, meaning the APB address width (4 KB slave window).
REQ-002 SHALL have parameter DEPTH, default 16, meaning elements per operand vector; legal range 1..256.
REQ-003 SHALL have parameter IN_WIDTH, default 8, meaning operand element width; legal range 2..16.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port HRESET  input  1  synchronous active-high reset.
REQ-007 SHALL have port PADDR  input  APB_ADDR_WIDTH  APB byte address; word index is PADDR[11:2].
REQ-008 SHALL have port PWDATA  input  32  APB write data.
REQ-009 SHALL have port PWRITE  input  1  APB write strobe.
REQ-010 SHALL have port PSEL  input  1  APB select.
REQ-011 SHALL have port PENABLE  input  1  APB access phase.
REQ-012 SHALL have port PRDATA  output  32  APB read data, combinational from PADDR.
REQ-013 SHALL have port PREADY  output  1  tied to 1.
REQ-014 SHALL have port PSLVERR  output  1  error flag for the current access phase.
REQ-015 SHALL have port irq  output  1  level interrupt, high while STATUS.done=1 and CTRL.irq_en=1.

Function
REQ-016 SHALL define a write access as PSEL&PENABLE&PWRITE and a read access as PSEL&PENABLE&!PWRITE.
REQ-017 SHALL decode this map: 0x000 CTRL (RW); 0x004 STATUS (RO); 0x008 LEN (RW); 0x00C DOT (RO); 0x400+4i A[i] (RW); 0x800+4i B[i] (RW); 0xC00+4i R[i] (RO); i < DEPTH.
REQ-018 SHALL implement CTRL as: bit0 start (write-1 pulse, reads 0); bit1 mode (0 = elementwise, 1 = dot product); bit2 signed; bit3 irq_en; bit4 clr_done (write-1 pulse, reads 0).
REQ-019 SHALL read STATUS as bit0 busy, bit1 done, all other bits 0.
REQ-020 SHALL store A[i] and B[i] from PWDATA[IN_WIDTH-1:0] and read them back zero-extended.
REQ-021 SHALL compute R[i] = A[i]*B[i] with width 2*IN_WIDTH, reading back zero-extended to 32 bits.
REQ-022 SHALL give DOT width 2*IN_WIDTH+clog2(DEPTH)+1, wrap modulo that width, and read back zero-extended.
REQ-023 SHALL apply two's-complement operands and product when signed=1, and unsigned otherwise.
REQ-024 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-025 SHALL transition IDLE->RUN on a start write, latching mode, signed and effective length N=min(LEN,DEPTH), clearing the element index and DOT, and clearing done.
REQ-026 SHALL process element k on the k-th RUN cycle, writing R[k] and adding to DOT in mode 1, or writing R[k] only in mode 0.
REQ-027 SHALL transition RUN->DONE after element N-1, so that busy is high for exactly N cycles.
REQ-028 SHALL, in DONE, set done=1 for one cycle and then return to IDLE, with done held until clr_done or the next start.
REQ-029 SHALL, when N=0, go IDLE->DONE directly (busy high 0 cycles), leaving DOT=0 and R unchanged.
REQ-030 SHALL ignore a start write while busy, and assert PSLVERR for that access.
REQ-031 SHALL, while busy, drop writes to LEN, A or B and assert PSLVERR; writes to CTRL bits 1..4 are accepted.
REQ-032 SHALL return R[i] for i >= N of the last run as its previous value.
REQ-033 SHALL let clr_done take priority when clr_done and start are written together, so that the run starts and done=0.
REQ-034 SHALL read unmapped or i >= DEPTH addresses as 0xFFFFFFFF, ignore writes to them, and keep PSLVERR=0 for those accesses.
REQ-035 SHALL keep PSLVERR=0 outside the access phase.

Reset
REQ-036 SHALL, with HRESET=1 at a rising edge, set: FSM=IDLE, busy=0, done=0, CTRL=0, LEN=DEPTH, DOT=0, irq=0.
REQ-037 SHALL leave A, B and R contents undefined after reset.
REQ-038 SHALL, on reset during RUN, abort the run, leave done=0 and raise no irq.

Verification
REQ-039 SHALL cover: unsigned dot with defaults, LEN=4, A={1,2,3,4}, B={5,6,7,8}, CTRL=0x3 -> busy 4 cycles, DOT=70, R={5,12,21,32}, done=1.
REQ-040 SHALL cover: signed elementwise, A[0]=0xFF, B[0]=0x02, LEN=1, CTRL=0x5 -> R[0]=0xFFFE, DOT=0.
REQ-041 SHALL cover: write B[0] and start while busy -> PSLVERR=1 on both, B[0] unchanged, and the run completes normally.
REQ-042 SHALL cover: LEN=0 with start -> done next cycle, busy never 1, DOT=0; LEN=100 with DEPTH=16 -> busy exactly 16 cycles.
REQ-043 SHALL cover: irq_en=1 run to done -> irq=1; clr_done write -> irq=0 the next cycle.
REQ-044 SHALL cover: HRESET pulse in RUN cycle 2 -> IDLE, STATUS=0, LEN=DEPTH; read 0x010 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/apb_vmac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_vmac                                                       |
// | Purpose  : APB-attached vector multiply / multiply-accumulate engine.     |
// |            Two operand vectors A and B are loaded over APB. A start write |
// |            then walks the first N=min(LEN,DEPTH) elements, one per clock. |
// |            Each step writes R[k]=A[k]*B[k]. In dot-product mode it also   |
// |            accumulates the product into DOT.                              |
// | Ports    : HCLK, HRESET         - clock, synchronous active-high reset    |
// |            PADDR/PWDATA/PWRITE/ - APB slave request                       |
// |            PSEL/PENABLE                                                   |
// |            PRDATA/PREADY/       - APB slave response (PRDATA is           |
// |            PSLVERR                combinational, PREADY is always 1)      |
// |            irq                  - level interrupt (done & irq_en)         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module apb_vmac #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DEPTH          = 16,
  parameter int IN_WIDTH       = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         PROD_W  = 2 * IN_WIDTH;
  localparam int         DOT_W   = PROD_W + $clog2(DEPTH) + 1;
  localparam logic [8:0] DEPTH_N = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand and result storage; deliberately not reset.
  logic [IN_WIDTH-1:0] a_mem [DEPTH];
  logic [IN_WIDTH-1:0] b_mem [DEPTH];
  logic [PROD_W-1:0]   r_mem [DEPTH];

  logic             mode_cfg, sgn_cfg, irq_en;
  logic [31:0]      len;
  logic             done;
  logic             mode_run, sgn_run;
  logic [8:0]       n_run;
  logic [8:0]       k;
  logic [DOT_W-1:0] dot;

  // ---------------------------------------------------------------- decode
  logic [1:0]       region;
  logic [7:0]       word_idx;
  logic [IDX_W-1:0] addr_idx;
  logic             in_range;
  logic             wr_acc, busy;
  logic             is_ctrl, is_len, is_a, is_b;

  assign region   = PADDR[11:10];
  assign word_idx = PADDR[9:2];
  assign addr_idx = word_idx[IDX_W-1:0];
  assign in_range = ({24'd0, word_idx} < 32'(DEPTH));
  assign wr_acc   = PSEL & PENABLE & PWRITE;
  assign busy     = (state == RUN);

  assign is_ctrl  = (region == 2'd0) && (word_idx == 8'd0);
  assign is_len   = (region == 2'd0) && (word_idx == 8'd2);
  assign is_a     = (region == 2'd1) && in_range;
  assign is_b     = (region == 2'd2) && in_range;

  // Byte-lane bits of the address are not decoded.
  logic unused_paddr_lo;
  assign unused_paddr_lo = ^PADDR[1:0];

  if (APB_ADDR_WIDTH > 12) begin : g_wide_addr
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[APB_ADDR_WIDTH-1:12];
  end

  logic start_req, start_ok, clr_req;
  logic ctrl_wr, len_wr_ok, a_wr_ok, b_wr_ok;

  assign ctrl_wr   = wr_acc & is_ctrl;
  assign start_req = ctrl_wr & PWDATA[0];
  assign start_ok  = start_req & ~busy;
  assign clr_req   = ctrl_wr & PWDATA[4];
  assign len_wr_ok = wr_acc & is_len & ~busy;
  assign a_wr_ok   = wr_acc & is_a & ~busy;
  assign b_wr_ok   = wr_acc & is_b & ~busy;

  // Only rejected accesses flag an error. wr_acc already implies the access
  // phase, so the flag is low during setup and idle cycles.
  assign PSLVERR = busy & (start_req | (wr_acc & (is_len | is_a | is_b)));
  assign PREADY  = 1'b1;
  assign irq     = done & irq_en;

  // ---------------------------------------------------------------- datapath
  logic [8:0]       n_eff;
  logic             last;
  logic [IDX_W-1:0] k_idx;
  logic [IN_WIDTH-1:0] cur_a, cur_b;
  logic [PROD_W-1:0]   ext_a, ext_b, prod;
  logic [DOT_W-1:0]    prod_ext;

  assign n_eff = (len >= 32'(DEPTH)) ? DEPTH_N : len[8:0];
  assign last  = (k == (n_run - 9'd1));
  assign k_idx = k[IDX_W-1:0];
  assign cur_a = a_mem[k_idx];
  assign cur_b = b_mem[k_idx];

  // Extending both operands to the full product width first makes the
  // truncated unsigned product equal the two's-complement product in
  // signed mode.
  assign ext_a    = {{IN_WIDTH{sgn_run & cur_a[IN_WIDTH-1]}}, cur_a};
  assign ext_b    = {{IN_WIDTH{sgn_run & cur_b[IN_WIDTH-1]}}, cur_b};
  assign prod     = ext_a * ext_b;
  assign prod_ext = {{(DOT_W-PROD_W){sgn_run & prod[PROD_W-1]}}, prod};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = (n_eff == 9'd0) ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // DONE lasts a single cycle, but it can still take a new start.
        if (start_ok) state_nxt = (n_eff == 9'd0) ? DONE : RUN;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic done_set;
  assign done_set = (busy & last) | (start_ok & (n_eff == 9'd0));

  // ---------------------------------------------------------------- registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mode_cfg <= 1'b0;
      sgn_cfg  <= 1'b0;
      irq_en   <= 1'b0;
      len      <= 32'(DEPTH);
      done     <= 1'b0;
      mode_run <= 1'b0;
      sgn_run  <= 1'b0;
      n_run    <= 9'd0;
      k        <= 9'd0;
      dot      <= '0;
    end else begin
      if (ctrl_wr) begin
        mode_cfg <= PWDATA[1];
        sgn_cfg  <= PWDATA[2];
        irq_en   <= PWDATA[3];
      end
      if (len_wr_ok) len <= PWDATA;

      if (start_ok) begin
        mode_run <= PWDATA[1];
        sgn_run  <= PWDATA[2];
        n_run    <= n_eff;
        k        <= 9'd0;
        dot      <= '0;
      end else if (busy) begin
        k <= k + 9'd1;
        if (mode_run) dot <= dot + prod_ext;
      end

      // A start (or clr_done) clears done unless the run ends immediately.
      if (done_set)                done <= 1'b1;
      else if (clr_req | start_ok) done <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (a_wr_ok) a_mem[addr_idx] <= PWDATA[IN_WIDTH-1:0];
    if (b_wr_ok) b_mem[addr_idx] <= PWDATA[IN_WIDTH-1:0];
    if (busy && !HRESET) r_mem[k_idx] <= prod;
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    PRDATA = 32'hFFFF_FFFF;
    case (region)
      2'd0: begin
        case (word_idx)
          8'd0:    PRDATA = {27'd0, 1'b0, irq_en, sgn_cfg, mode_cfg, 1'b0};
          8'd1:    PRDATA = {30'd0, done, busy};
          8'd2:    PRDATA = len;
          8'd3:    PRDATA = 32'(dot);
          default: PRDATA = 32'hFFFF_FFFF;
        endcase
      end
      2'd1:    if (in_range) PRDATA = 32'(a_mem[addr_idx]);
      2'd2:    if (in_range) PRDATA = 32'(b_mem[addr_idx]);
      default: if (in_range) PRDATA = 32'(r_mem[addr_idx]);
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_vmac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_vmac                                                    |
// | Purpose  : Directed self-checking bench for apb_vmac (default params).    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_apb_vmac;

  logic        clk;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq;

  int checks = 0;
  int errors = 0;

  apb_vmac #(.APB_ADDR_WIDTH(12), .DEPTH(16), .IN_WIDTH(8)) dut (
    .HCLK    (clk),
    .HRESET  (HRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- bus tasks
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Watches STATUS combinationally each cycle until done=1 or the budget runs out.
  task automatic wait_done(output int busy_cnt, output int cyc, output bit ok);
    busy_cnt = 0; cyc = 0; ok = 1'b0;
    PADDR = 12'h004;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (PRDATA[0]) busy_cnt++;
      if (PRDATA[1]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] rd; logic e;
    HRESET = 1'b1;
    repeat (3) @(posedge clk);
    #1 HRESET = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset.irq: got %b expected 0", irq); end
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL reset.pready: got %b expected 1", PREADY); end
    apb_read(12'h004, rd, e);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset.status: got %h expected 00000000", rd); end
    apb_read(12'h000, rd, e);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset.ctrl: got %h expected 00000000", rd); end
    apb_read(12'h008, rd, e);
    checks++; if (rd !== 32'd16) begin errors++; $display("FAIL reset.len: got %0d expected 16", rd); end
    apb_read(12'h00C, rd, e);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset.dot: got %0d expected 0", rd); end
  endtask

  task automatic test_dot_unsigned();
    logic [31:0] rd; logic e; int bc, cyc; bit ok;
    logic [31:0] exp_r [4];
    exp_r = '{32'd5, 32'd12, 32'd21, 32'd32};
    apb_write(12'h008, 32'd4, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL dot.len_err: got %b expected 0", e); end
    for (int i = 0; i < 4; i++) begin
      apb_write(12'h400 + 12'(4*i), 32'(i + 1), e);
      apb_write(12'h800 + 12'(4*i), 32'(i + 5), e);
    end
    apb_write(12'h000, 32'h3, e);
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dot.done_timeout: got %b expected 1", ok); end
    checks++; if (bc != 4) begin errors++; $display("FAIL dot.busy_cycles: got %0d expected 4", bc); end
    apb_read(12'h00C, rd, e);
    checks++; if (rd !== 32'd70) begin errors++; $display("FAIL dot.dot: got %0d expected 70", rd); end
    for (int i = 0; i < 4; i++) begin
      apb_read(12'hC00 + 12'(4*i), rd, e);
      checks++; if (rd !== exp_r[i]) begin errors++; $display("FAIL dot.r%0d: got %0d expected %0d", i, rd, exp_r[i]); end
    end
    apb_read(12'h004, rd, e);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL dot.status: got %h expected 00000002", rd); end
    apb_read(12'h000, rd, e);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL dot.ctrl_rb: got %h expected 00000002", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL dot.irq: got %b expected 0", irq); end
  endtask

  task automatic test_signed_elem();
    logic [31:0] rd; logic e; int bc, cyc; bit ok;
    apb_write(12'h400, 32'hFFFF_FFFF, e);   // only the low byte is stored
    apb_write(12'h800, 32'h2, e);
    apb_write(12'h008, 32'd1, e);
    apb_write(12'h000, 32'h5, e);
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL signed.done_timeout: got %b expected 1", ok); end
    apb_read(12'hC00, rd, e);
    checks++; if (rd !== 32'h0000_FFFE) begin errors++; $display("FAIL signed.r0: got %h expected 0000fffe", rd); end
    apb_read(12'h00C, rd, e);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL signed.dot: got %0d expected 0", rd); end
    apb_read(12'h400, rd, e);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL signed.a0_rb: got %h expected 000000ff", rd); end
    apb_read(12'hC04, rd, e);
    checks++; if (rd !== 32'd12) begin errors++; $display("FAIL signed.r1_kept: got %0d expected 12", rd); end
  endtask

  task automatic test_busy_errors();
    logic [31:0] rd; logic e, e_b, e_s; int bc, cyc; bit ok;
    for (int i = 0; i < 8; i++) begin
      apb_write(12'h400 + 12'(4*i), 32'(i + 1), e);
      apb_write(12'h800 + 12'(4*i), 32'(i + 1), e);
    end
    apb_write(12'h008, 32'd8, e);
    apb_write(12'h000, 32'h3, e);           // start, commits at edge e0
    apb_write(12'h800, 32'h55, e_b);        // commits at e2, still busy
    apb_write(12'h000, 32'h3, e_s);         // commits at e4, still busy
    checks++; if (e_b !== 1'b1) begin errors++; $display("FAIL busy.b_write_err: got %b expected 1", e_b); end
    checks++; if (e_s !== 1'b1) begin errors++; $display("FAIL busy.start_err: got %b expected 1", e_s); end
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy.done_timeout: got %b expected 1", ok); end
    checks++; if (bc != 4) begin errors++; $display("FAIL busy.remaining_busy: got %0d expected 4", bc); end
    apb_read(12'h800, rd, e);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL busy.b0_kept: got %0d expected 1", rd); end
    apb_read(12'h00C, rd, e);
    checks++; if (rd !== 32'd204) begin errors++; $display("FAIL busy.dot: got %0d expected 204", rd); end
  endtask

  task automatic test_len_edges();
    logic [31:0] rd; logic e; int bc, cyc; bit ok;
    apb_write(12'h008, 32'd0, e);
    apb_write(12'h000, 32'h3, e);
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len0.done_timeout: got %b expected 1", ok); end
    checks++; if (cyc != 1) begin errors++; $display("FAIL len0.done_latency: got %0d expected 1", cyc); end
    checks++; if (bc != 0) begin errors++; $display("FAIL len0.busy_cycles: got %0d expected 0", bc); end
    apb_read(12'h00C, rd, e);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL len0.dot: got %0d expected 0", rd); end
    apb_read(12'hC00, rd, e);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL len0.r0_kept: got %0d expected 1", rd); end
    apb_write(12'h008, 32'd100, e);
    apb_write(12'h000, 32'h1, e);
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len100.done_timeout: got %b expected 1", ok); end
    checks++; if (bc != 16) begin errors++; $display("FAIL len100.busy_cycles: got %0d expected 16", bc); end
    apb_read(12'h008, rd, e);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL len100.len_rb: got %0d expected 100", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic e; int bc, cyc; bit ok;
    apb_write(12'h008, 32'd2, e);
    apb_write(12'h000, 32'h9, e);
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL irq.done_timeout: got %b expected 1", ok); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq.raised: got %b expected 1", irq); end
    apb_write(12'h000, 32'h18, e);          // clr_done, keep irq_en
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq.cleared: got %b expected 0", irq); end
    apb_read(12'h000, rd, e);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL irq.ctrl_rb: got %h expected 00000008", rd); end
    apb_write(12'h000, 32'h19, e);          // clr_done and start together
    PADDR = 12'h004;
    #1;
    checks++; if (PRDATA !== 32'h1) begin errors++; $display("FAIL irq.clr_start_status: got %h expected 00000001", PRDATA); end
    wait_done(bc, cyc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL irq.rerun_timeout: got %b expected 1", ok); end
  endtask

  task automatic test_reset_in_run();
    logic [31:0] rd; logic e;
    apb_write(12'h008, 32'd4, e);
    apb_write(12'h000, 32'hB, e);           // start commits at e0
    @(posedge clk);                         // e1: end of RUN cycle 1
    #1 HRESET = 1'b1;
    @(posedge clk);                         // e2: reset during RUN cycle 2
    #1 HRESET = 1'b0;
    PADDR = 12'h004;
    #1;
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rstrun.status: got %h expected 00000000", PRDATA); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstrun.irq: got %b expected 0", irq); end
    apb_read(12'h008, rd, e);
    checks++; if (rd !== 32'd16) begin errors++; $display("FAIL rstrun.len: got %0d expected 16", rd); end
    apb_read(12'h010, rd, e);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstrun.unmapped_rd: got %h expected ffffffff", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rstrun.unmapped_rd_err: got %b expected 0", e); end
    apb_read(12'hC40, rd, e);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstrun.r16_rd: got %h expected ffffffff", rd); end
    apb_write(12'h010, 32'h1234, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rstrun.unmapped_wr_err: got %b expected 0", e); end
    repeat (6) @(posedge clk);
    PADDR = 12'h004;
    #1;
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rstrun.status_later: got %h expected 00000000", PRDATA); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstrun.irq_later: got %b expected 0", irq); end
  endtask

  initial begin
    HRESET = 1'b1; PADDR = 12'h0; PWDATA = 32'h0;
    PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    test_reset();
    test_dot_unsigned();
    test_signed_elem();
    test_busy_errors();
    test_len_edges();
    test_irq();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
